// File: rtl/control_pkg.sv
// Shared definitions for the SAW control sequencer: opcodes, one-hot T-states,
// control-word bit map, FSM state encoding and the execute-phase microcode lookup.
package control_pkg;

   typedef logic [17:0] ctrl_word_t;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_STA = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1000;
   localparam logic [3:0] OP_LDI = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1010;
   localparam logic [3:0] OP_JZ  = 4'b1011;
   localparam logic [3:0] OP_JN  = 4'b1100;
   localparam logic [3:0] OP_OUT = 4'b1101;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [4:0] T0 = 5'b00001;
   localparam logic [4:0] T1 = 5'b00010;
   localparam logic [4:0] T2 = 5'b00100;
   localparam logic [4:0] T3 = 5'b01000;
   localparam logic [4:0] T4 = 5'b10000;

   localparam int CTRL_PC_INC  = 0;
   localparam int CTRL_PC_OUT  = 1;
   localparam int CTRL_JMP     = 2;
   localparam int CTRL_MAR_IN  = 3;
   localparam int CTRL_RAM_OUT = 4;
   localparam int CTRL_RAM_IN  = 5;
   localparam int CTRL_IR_IN   = 6;
   localparam int CTRL_IR_OUT  = 7;
   localparam int CTRL_ACC_IN  = 8;
   localparam int CTRL_ACC_OUT = 9;
   localparam int CTRL_BR_IN   = 10;
   localparam int CTRL_ALU_OUT = 11;
   localparam int CTRL_ALU_SUB = 12;
   localparam int CTRL_ALU_AND = 13;
   localparam int CTRL_ALU_OR  = 14;
   localparam int CTRL_ALU_XOR = 15;
   localparam int CTRL_OUT_IN  = 16;
   localparam int CTRL_HLT_SIG = 17;

   localparam ctrl_word_t CW_PC_INC  = ctrl_word_t'(1) << CTRL_PC_INC;
   localparam ctrl_word_t CW_PC_OUT  = ctrl_word_t'(1) << CTRL_PC_OUT;
   localparam ctrl_word_t CW_JMP     = ctrl_word_t'(1) << CTRL_JMP;
   localparam ctrl_word_t CW_MAR_IN  = ctrl_word_t'(1) << CTRL_MAR_IN;
   localparam ctrl_word_t CW_RAM_OUT = ctrl_word_t'(1) << CTRL_RAM_OUT;
   localparam ctrl_word_t CW_RAM_IN  = ctrl_word_t'(1) << CTRL_RAM_IN;
   localparam ctrl_word_t CW_IR_IN   = ctrl_word_t'(1) << CTRL_IR_IN;
   localparam ctrl_word_t CW_IR_OUT  = ctrl_word_t'(1) << CTRL_IR_OUT;
   localparam ctrl_word_t CW_ACC_IN  = ctrl_word_t'(1) << CTRL_ACC_IN;
   localparam ctrl_word_t CW_ACC_OUT = ctrl_word_t'(1) << CTRL_ACC_OUT;
   localparam ctrl_word_t CW_BR_IN   = ctrl_word_t'(1) << CTRL_BR_IN;
   localparam ctrl_word_t CW_ALU_OUT = ctrl_word_t'(1) << CTRL_ALU_OUT;
   localparam ctrl_word_t CW_ALU_SUB = ctrl_word_t'(1) << CTRL_ALU_SUB;
   localparam ctrl_word_t CW_ALU_AND = ctrl_word_t'(1) << CTRL_ALU_AND;
   localparam ctrl_word_t CW_ALU_OR  = ctrl_word_t'(1) << CTRL_ALU_OR;
   localparam ctrl_word_t CW_ALU_XOR = ctrl_word_t'(1) << CTRL_ALU_XOR;
   localparam ctrl_word_t CW_OUT_IN  = ctrl_word_t'(1) << CTRL_OUT_IN;
   localparam ctrl_word_t CW_HLT_SIG = ctrl_word_t'(1) << CTRL_HLT_SIG;

   localparam ctrl_word_t CW_FETCH0 = CW_PC_OUT | CW_MAR_IN;
   localparam ctrl_word_t CW_FETCH1 = CW_PC_INC | CW_RAM_OUT | CW_IR_IN;
   localparam ctrl_word_t CW_RAM    = CW_RAM_OUT | CW_RAM_IN;
   // Register loads and the PC increment must fire exactly once per stretched state.
   localparam ctrl_word_t CW_FINAL_ONLY = CW_PC_INC | CW_IR_IN | CW_ACC_IN | CW_BR_IN;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH0 = 3'd1;
   localparam logic [2:0] ST_FETCH1 = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   function automatic logic [4:0] exec_last_t(input logic [3:0] op);
      case (op)
         OP_LDA, OP_STA:                         return T3;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  return T4;
         default:                                return T2;
      endcase
   endfunction

   function automatic ctrl_word_t alu_sel(input logic [3:0] op);
      case (op)
         OP_SUB:  return CW_ALU_SUB;
         OP_AND:  return CW_ALU_AND;
         OP_OR:   return CW_ALU_OR;
         OP_XOR:  return CW_ALU_XOR;
         // AND and OR selected together make the ALU invert the accumulator.
         OP_NOT:  return CW_ALU_AND | CW_ALU_OR;
         default: return '0;
      endcase
   endfunction

   function automatic ctrl_word_t exec_word(input logic [3:0] op, input logic [4:0] t,
                                            input logic z, input logic n);
      ctrl_word_t w;
      w = '0;
      case (op)
         OP_LDA: begin
            if (t == T2)      w = CW_IR_OUT | CW_MAR_IN;
            else if (t == T3) w = CW_RAM_OUT | CW_ACC_IN;
         end
         OP_STA: begin
            if (t == T2)      w = CW_IR_OUT | CW_MAR_IN;
            else if (t == T3) w = CW_ACC_OUT | CW_RAM_IN;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            if (t == T2)      w = CW_IR_OUT | CW_MAR_IN;
            else if (t == T3) w = CW_RAM_OUT | CW_BR_IN;
            else if (t == T4) w = CW_ALU_OUT | CW_ACC_IN | alu_sel(op);
         end
         OP_NOT: if (t == T2) w = CW_ALU_OUT | CW_ACC_IN | alu_sel(op);
         OP_LDI: if (t == T2) w = CW_IR_OUT | CW_ACC_IN;
         OP_JMP: if (t == T2) w = CW_IR_OUT | CW_JMP;
         OP_JZ:  if (t == T2 && z) w = CW_IR_OUT | CW_JMP;
         OP_JN:  if (t == T2 && n) w = CW_IR_OUT | CW_JMP;
         OP_OUT: if (t == T2) w = CW_ACC_OUT | CW_OUT_IN;
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// RAM wait-state timer: 2-bit down-counter loaded with RAM_WAIT on entry to a
// RAM state; last_cycle is high once the count reaches zero.
module ctrl_wait_timer #(
   parameter int RAM_WAIT = 0
) (
   input  logic i_clock,
   input  logic i_clear_n,
   input  logic i_load,
   output logic o_last_cycle
);

   localparam logic [1:0] LOAD_VAL = 2'(RAM_WAIT);

   logic [1:0] r_count;

   always_ff @(negedge i_clock or negedge i_clear_n) begin
      if (!i_clear_n) begin
         r_count <= 2'd0;
      end else if (i_load) begin
         r_count <= LOAD_VAL;
      end else if (r_count != 2'd0) begin
         r_count <= r_count - 2'd1;
      end
   end

   assign o_last_cycle = (r_count == 2'd0);

endmodule

// File: rtl/control_seq.sv
// Ring-counter control sequencer for the SAW CPU, clocked on the falling edge.
// Define STEP_MODE_EN to add the step input and run one instruction per pulse.
//
// state  | meaning
// IDLE   | after reset (and before every T0 in step mode): ctrl_word=0, t_state=T0
// FETCH0 | T0, PC to MAR
// FETCH1 | T1, RAM to IR, PC increment (stretched by RAM wait states)
// EXEC   | T2..T4, opcode microcode; T3 RAM accesses are stretched
// HALT   | hlt_sig only, t_state held at T2 until resume
module control_seq
   import control_pkg::*;
#(
   parameter int RAM_WAIT = 0,
   parameter int VAR_LEN  = 1
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic [3:0]  instruction,
   input  logic        zero_flag,
   input  logic        neg_flag,
   input  logic        resume,
`ifdef STEP_MODE_EN
   input  logic        step,
`endif
   output logic [17:0] ctrl_word,
   output logic [4:0]  t_state,
   output logic        halted
);

   logic [2:0] r_state;
   logic [4:0] r_t;
   ctrl_word_t r_ctrl;

   logic [2:0] w_state_nxt;
   logic [4:0] w_t_nxt;
   ctrl_word_t w_ctrl_nxt;
   logic [2:0] w_end_state;
   logic       w_start;
   logic       w_last;
   logic       w_hold;
   logic       w_load;
   logic       w_exec_done;

`ifdef STEP_MODE_EN
   assign w_start     = step;
   assign w_end_state = ST_IDLE;
`else
   assign w_start     = 1'b1;
   assign w_end_state = ST_FETCH0;
`endif

   // A RAM state stays put until the wait timer reports its final cycle.
   assign w_hold      = ((r_ctrl & CW_RAM) != '0) && !w_last;
   assign w_exec_done = (VAR_LEN != 0) ? (r_t == exec_last_t(instruction)) : (r_t == T4);

   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      if (!w_hold) begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  w_state_nxt = ST_FETCH0;
                  w_t_nxt     = T0;
               end
            end
            ST_FETCH0: begin
               w_state_nxt = ST_FETCH1;
               w_t_nxt     = T1;
            end
            ST_FETCH1: begin
               w_state_nxt = (instruction == OP_HLT) ? ST_HALT : ST_EXEC;
               w_t_nxt     = T2;
            end
            ST_EXEC: begin
               if (w_exec_done) begin
                  w_state_nxt = w_end_state;
                  w_t_nxt     = T0;
               end else begin
                  w_t_nxt = r_t << 1;
               end
            end
            ST_HALT: begin
               if (resume) begin
                  w_state_nxt = w_end_state;
                  w_t_nxt     = T0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_t_nxt     = T0;
            end
         endcase
      end
   end

   // The word is registered, so flags are captured on the edge that enters T2.
   always_comb begin
      w_ctrl_nxt = '0;
      if (w_hold) begin
         w_ctrl_nxt = r_ctrl;
      end else begin
         case (w_state_nxt)
            ST_FETCH0: w_ctrl_nxt = CW_FETCH0;
            ST_FETCH1: w_ctrl_nxt = CW_FETCH1;
            ST_EXEC:   w_ctrl_nxt = exec_word(instruction, w_t_nxt, zero_flag, neg_flag);
            ST_HALT:   w_ctrl_nxt = CW_HLT_SIG;
            default:   w_ctrl_nxt = '0;
         endcase
      end
      w_load = !w_hold && ((w_ctrl_nxt & CW_RAM) != '0);
   end

   always_ff @(negedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= ST_IDLE;
         r_t     <= T0;
         r_ctrl  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_t     <= w_t_nxt;
         r_ctrl  <= w_ctrl_nxt;
      end
   end

   ctrl_wait_timer #(
      .RAM_WAIT (RAM_WAIT)
   ) u_wait (
      .i_clock      (clock),
      .i_clear_n    (clear_n),
      .i_load       (w_load),
      .o_last_cycle (w_last)
   );

   assign ctrl_word = w_last ? r_ctrl : (r_ctrl & ~CW_FINAL_ONLY);
   assign t_state   = r_t;
   assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: two instances (RAM_WAIT=0/VAR_LEN=1 and
// RAM_WAIT=2/VAR_LEN=0); per-cycle expectations are queued as each instruction is issued.
module tb_control_seq;

   localparam logic [17:0] B_PC_INC  = 18'd1 << 0;
   localparam logic [17:0] B_PC_OUT  = 18'd1 << 1;
   localparam logic [17:0] B_JMP     = 18'd1 << 2;
   localparam logic [17:0] B_MAR_IN  = 18'd1 << 3;
   localparam logic [17:0] B_RAM_OUT = 18'd1 << 4;
   localparam logic [17:0] B_RAM_IN  = 18'd1 << 5;
   localparam logic [17:0] B_IR_IN   = 18'd1 << 6;
   localparam logic [17:0] B_IR_OUT  = 18'd1 << 7;
   localparam logic [17:0] B_ACC_IN  = 18'd1 << 8;
   localparam logic [17:0] B_ACC_OUT = 18'd1 << 9;
   localparam logic [17:0] B_BR_IN   = 18'd1 << 10;
   localparam logic [17:0] B_ALU_OUT = 18'd1 << 11;
   localparam logic [17:0] B_ALU_SUB = 18'd1 << 12;
   localparam logic [17:0] B_ALU_AND = 18'd1 << 13;
   localparam logic [17:0] B_ALU_OR  = 18'd1 << 14;
   localparam logic [17:0] B_ALU_XOR = 18'd1 << 15;
   localparam logic [17:0] B_OUT_IN  = 18'd1 << 16;
   localparam logic [17:0] B_HLT     = 18'd1 << 17;
   localparam logic [17:0] B_FINAL   = B_PC_INC | B_IR_IN | B_ACC_IN | B_BR_IN;

   localparam logic [4:0] TS0 = 5'b00001;
   localparam logic [4:0] TS1 = 5'b00010;
   localparam logic [4:0] TS2 = 5'b00100;

   localparam logic [3:0] OP_NOP = 4'd0,  OP_LDA = 4'd1,  OP_STA = 4'd2,  OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8,  OP_LDI = 4'd9,  OP_JMP = 4'd10, OP_JZ  = 4'd11;
   localparam logic [3:0] OP_JN  = 4'd12, OP_OUT = 4'd13, OP_UNL = 4'd14, OP_HLT = 4'd15;

   logic        clock;
   logic        clear_n;
   logic [3:0]  instr [2];
   logic        zf    [2];
   logic        nf    [2];
   logic        rsm   [2];
   logic        stp   [2];
   logic [17:0] cw    [2];
   logic [4:0]  ts    [2];
   logic        hl    [2];

   int          n_checks;
   int          n_errors;
   int          sel;
   string       cur_tag;
   logic [23:0] exp_q [$];

   control_seq #(.RAM_WAIT(0), .VAR_LEN(1)) dut0 (
      .clock(clock), .clear_n(clear_n), .instruction(instr[0]),
      .zero_flag(zf[0]), .neg_flag(nf[0]), .resume(rsm[0]),
`ifdef STEP_MODE_EN
      .step(stp[0]),
`endif
      .ctrl_word(cw[0]), .t_state(ts[0]), .halted(hl[0]));

   control_seq #(.RAM_WAIT(2), .VAR_LEN(0)) dut2 (
      .clock(clock), .clear_n(clear_n), .instruction(instr[1]),
      .zero_flag(zf[1]), .neg_flag(nf[1]), .resume(rsm[1]),
`ifdef STEP_MODE_EN
      .step(stp[1]),
`endif
      .ctrl_word(cw[1]), .t_state(ts[1]), .halted(hl[1]));

   initial clock = 1'b1;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int wait_of(input int s);
      return (s == 1) ? 2 : 0;
   endfunction

   function automatic int exec_states(input int s, input logic [3:0] op);
      if (s == 1) return 3;
      case (op)
         OP_LDA, OP_STA:                         return 2;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  return 3;
         default:                                return 1;
      endcase
   endfunction

   function automatic logic [17:0] model_word(input logic [3:0] op, input int k,
                                              input logic z, input logic n);
      logic [17:0] alu;
      case (op)
         OP_SUB:  alu = B_ALU_SUB;
         OP_AND:  alu = B_ALU_AND;
         OP_OR:   alu = B_ALU_OR;
         OP_XOR:  alu = B_ALU_XOR;
         default: alu = '0;
      endcase
      case (op)
         OP_LDA: return (k == 2) ? (B_IR_OUT | B_MAR_IN) : (k == 3) ? (B_RAM_OUT | B_ACC_IN) : '0;
         OP_STA: return (k == 2) ? (B_IR_OUT | B_MAR_IN) : (k == 3) ? (B_ACC_OUT | B_RAM_IN) : '0;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
            return (k == 2) ? (B_IR_OUT | B_MAR_IN) : (k == 3) ? (B_RAM_OUT | B_BR_IN)
                 : (B_ALU_OUT | B_ACC_IN | alu);
         OP_NOT: return (k == 2) ? (B_ALU_OUT | B_ACC_IN | B_ALU_AND | B_ALU_OR) : '0;
         OP_LDI: return (k == 2) ? (B_IR_OUT | B_ACC_IN) : '0;
         OP_JMP: return (k == 2) ? (B_IR_OUT | B_JMP) : '0;
         OP_JZ:  return (k == 2 && z) ? (B_IR_OUT | B_JMP) : '0;
         OP_JN:  return (k == 2 && n) ? (B_IR_OUT | B_JMP) : '0;
         OP_OUT: return (k == 2) ? (B_ACC_OUT | B_OUT_IN) : '0;
         default: return '0;
      endcase
   endfunction

   function automatic void push(input logic h, input logic [4:0] t, input logic [17:0] c);
      exp_q.push_back({h, t, c});
   endfunction

   function automatic void push_state(input logic [4:0] t, input logic [17:0] c, input int w);
      if ((c & (B_RAM_OUT | B_RAM_IN)) != '0) begin
         for (int i = 0; i <= w; i++) push(1'b0, t, (i == w) ? c : (c & ~B_FINAL));
      end else begin
         push(1'b0, t, c);
      end
   endfunction

   task automatic step_cycle();
      logic [23:0] e;
      @(posedge clock);
      e = exp_q.pop_front();
      check_val(cur_tag, {8'h0, hl[sel], ts[sel], cw[sel]}, {8'h0, e});
      rsm[sel] = 1'b0;
      stp[sel] = 1'b0;
   endtask

   task automatic drain();
      while (exp_q.size() > 0) step_cycle();
   endtask

   // Queues the whole instruction, then compares up to and including its T0.
   task automatic start_instr(input logic [3:0] op, input logic z, input logic n, input bit noise);
      int w;
      w = wait_of(sel);
      cur_tag = $sformatf("dut%0d_op%0d_z%0d_n%0d", sel, op, z, n);
`ifdef STEP_MODE_EN
      push(1'b0, TS0, '0);
`endif
      push(1'b0, TS0, B_PC_OUT | B_MAR_IN);
      push_state(TS1, B_PC_INC | B_RAM_OUT | B_IR_IN, w);
      for (int k = 0; k < exec_states(sel, op); k++)
         push_state(TS2 << k, model_word(op, k + 2, z, n), w);
`ifdef STEP_MODE_EN
      step_cycle();
      stp[sel] = 1'b1;
`endif
      step_cycle();
      instr[sel] = op;
      zf[sel]    = z;
      nf[sel]    = n;
      if (noise) begin
         rsm[sel] = 1'b1;
         stp[sel] = 1'b1;
      end
   endtask

   task automatic run_instr(input logic [3:0] op, input logic z, input logic n, input bit noise);
      start_instr(op, z, n, noise);
      drain();
   endtask

   task automatic run_halt(input int ncyc);
      cur_tag = $sformatf("dut%0d_hlt", sel);
`ifdef STEP_MODE_EN
      push(1'b0, TS0, '0);
`endif
      push(1'b0, TS0, B_PC_OUT | B_MAR_IN);
      push_state(TS1, B_PC_INC | B_RAM_OUT | B_IR_IN, wait_of(sel));
      for (int i = 0; i < ncyc; i++) push(1'b1, TS2, B_HLT);
`ifdef STEP_MODE_EN
      step_cycle();
      stp[sel] = 1'b1;
`endif
      step_cycle();
      instr[sel] = OP_HLT;
      drain();
      rsm[sel] = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      sel      = 0;
      cur_tag  = "init";
      clear_n  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         instr[i] = OP_NOP; zf[i] = 1'b0; nf[i] = 1'b0; rsm[i] = 1'b0; stp[i] = 1'b0;
      end
      repeat (2) @(posedge clock);
      for (int i = 0; i < 2; i++) begin
         check_val("rst_ctrl", {14'h0, cw[i]}, 32'h0);
         check_val("rst_t", {27'h0, ts[i]}, {27'h0, TS0});
         check_val("rst_halted", {31'h0, hl[i]}, 32'h0);
      end
      clear_n = 1'b1;

`ifdef STEP_MODE_EN
      cur_tag = "step_idle";
      for (int i = 0; i < 10; i++) push(1'b0, TS0, '0);
      drain();
`endif
      run_instr(OP_ADD, 1'b0, 1'b0, 1'b0);
      run_instr(OP_LDI, 1'b0, 1'b0, 1'b0);
      run_instr(OP_NOP, 1'b0, 1'b0, 1'b0);
      run_instr(OP_LDA, 1'b0, 1'b0, 1'b0);
      run_instr(OP_STA, 1'b0, 1'b0, 1'b0);
      run_instr(OP_SUB, 1'b0, 1'b0, 1'b0);
      run_instr(OP_AND, 1'b0, 1'b0, 1'b0);
      run_instr(OP_OR,  1'b0, 1'b0, 1'b0);
      run_instr(OP_XOR, 1'b0, 1'b0, 1'b0);
      run_instr(OP_NOT, 1'b0, 1'b0, 1'b0);
      run_instr(OP_JMP, 1'b0, 1'b0, 1'b0);
      run_instr(OP_OUT, 1'b0, 1'b0, 1'b0);
      run_instr(OP_UNL, 1'b0, 1'b0, 1'b0);
      run_instr(OP_JZ,  1'b1, 1'b0, 1'b0);
      run_instr(OP_JZ,  1'b0, 1'b1, 1'b0);
      run_instr(OP_JN,  1'b0, 1'b1, 1'b0);
      run_instr(OP_JN,  1'b1, 1'b0, 1'b0);

      run_halt(20);
      run_instr(OP_LDI, 1'b0, 1'b0, 1'b1);
      run_instr(OP_ADD, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of LDA T3.
      start_instr(OP_LDA, 1'b0, 1'b0, 1'b0);
      repeat (3) step_cycle();
      #2 clear_n = 1'b0;
      #1;
      check_val("midrst_ctrl", {14'h0, cw[0]}, 32'h0);
      check_val("midrst_t", {27'h0, ts[0]}, {27'h0, TS0});
      check_val("midrst_halted", {31'h0, hl[0]}, 32'h0);
      exp_q.delete();
      @(posedge clock);
      clear_n = 1'b1;
      run_instr(OP_NOP, 1'b0, 1'b0, 1'b0);

      // Second instance: RAM wait states and fixed-length instructions.
      @(posedge clock);
      clear_n = 1'b0;
      @(posedge clock);
      clear_n = 1'b1;
      exp_q.delete();
      sel = 1;
      run_instr(OP_STA, 1'b0, 1'b0, 1'b0);
      run_instr(OP_ADD, 1'b0, 1'b0, 1'b0);
      run_instr(OP_JZ,  1'b1, 1'b0, 1'b0);
      run_instr(OP_JN,  1'b0, 1'b0, 1'b0);
      run_halt(5);
      run_instr(OP_LDA, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
